// File: rtl/perf_counter_sampler.sv
// perf_counter_sampler
//   Snapshots NumCounters performance counter values on a programmable cycle
//   interval or on a software request. Snapshots are buffered in a small FIFO
//   and streamed to the trace/debug sink one counter value per beat.
//   Snapshots that arrive while the FIFO is full are dropped and counted.
//
//   Optional feature macro: PERF_SAMPLER_DELTA_EN
//     defined   -> each FIFO entry holds per-counter deltas since the last
//                  accepted snapshot (modulo 2^CntWidth).
//     undefined -> each FIFO entry holds absolute counter values.
//
//   Output handshake (valid/ready): a beat transfers on a rising clock edge
//   where sample_valid_o && sample_ready_i. While sample_valid_o is high and
//   sample_ready_i is low, sample_data_o/sample_idx_o/sample_last_o hold
//   stable and sample_valid_o stays high until the beat transfers. Only a
//   reset can withdraw a pending beat.
//
//   state_dbg_o exposes the output FSM state (0 = IDLE, 1 = STREAM).
module perf_counter_sampler #(
   parameter int unsigned NumCounters = 6,
   parameter int unsigned FifoDepth   = 4,
   parameter int unsigned CntWidth    = 64
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            en_i,
   input  logic                            debug_mode_i,
   input  logic [31:0]                     interval_i,
   input  logic                            snap_req_i,
   input  logic [NumCounters*CntWidth-1:0] counter_i,
   output logic                            sample_valid_o,
   input  logic                            sample_ready_i,
   output logic [CntWidth-1:0]             sample_data_o,
   output logic [2:0]                      sample_idx_o,
   output logic                            sample_last_o,
   output logic [15:0]                     drop_cnt_o,
   input  logic                            drop_clr_i,
   output logic                            busy_o,
   output logic                            state_dbg_o
);

   localparam int unsigned EntryW = NumCounters * CntWidth;
   localparam int unsigned PtrW   = $clog2(FifoDepth);
   localparam logic [2:0]  LastIdx  = 3'(NumCounters - 1);
   localparam logic [PtrW:0] DepthCnt = FifoDepth[PtrW:0];

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_e;

   // ------------------------------------------------------------------
   // Interval timer and trigger
   // ------------------------------------------------------------------
   logic [31:0] timer_q, timer_d;
   logic        timer_run;
   logic        periodic_trig;
   logic        trig;

   // Timer advances only while enabled, not in debug, and with a non-zero
   // period. A period shrunk below the current count simply lets the timer
   // run on and wrap at 2^32 without firing.
   always_comb begin
      timer_run     = en_i && !debug_mode_i && (interval_i != 32'd0);
      periodic_trig = timer_run && (timer_q == (interval_i - 32'd1));
      trig          = (periodic_trig || snap_req_i) && !debug_mode_i;
      timer_d       = timer_q;
      if (!en_i) begin
         timer_d = '0;
      end else if (periodic_trig) begin
         timer_d = '0;
      end else if (timer_run) begin
         timer_d = timer_q + 32'd1;
      end
   end

   // Timer register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   // ------------------------------------------------------------------
   // Output FSM state (declared early: the pop depends on it)
   // ------------------------------------------------------------------
   state_e      state_q, state_d;
   logic [2:0]  beat_q, beat_d;
   logic        handshake;

   // ------------------------------------------------------------------
   // Snapshot FIFO
   // ------------------------------------------------------------------
   logic [EntryW-1:0] mem_q [FifoDepth];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]     count_q, count_d;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push;
   logic              pop;
   logic              drop;
   logic [EntryW-1:0] push_data;

   // A pop on the final beat frees a slot in the same cycle, so a trigger
   // arriving then is accepted even when the FIFO reads as full.
   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == DepthCnt);
      handshake  = (state_q == ST_STREAM) && sample_ready_i;
      pop        = handshake && (beat_q == LastIdx);
      push       = trig && (!fifo_full || pop);
      drop       = trig && fifo_full && !pop;
      count_d    = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

`ifdef PERF_SAMPLER_DELTA_EN
   logic [EntryW-1:0] prev_q;

   // Per-counter difference against the last accepted snapshot; modular
   // subtraction turns a counter wrap into the correct small delta.
   always_comb begin
      push_data = '0;
      for (int k = 0; k < int'(NumCounters); k++) begin
         push_data[k*CntWidth +: CntWidth] =
            counter_i[k*CntWidth +: CntWidth] - prev_q[k*CntWidth +: CntWidth];
      end
   end

   // Reference values move only on accepted pushes, so a dropped snapshot
   // folds into the next delta.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q <= '0;
      end else if (push) begin
         prev_q <= counter_i;
      end
   end
`else
   // Absolute values are stored as-is.
   always_comb begin
      push_data = counter_i;
   end
`endif

   // FIFO storage; contents need no reset because occupancy gates reads.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   // ------------------------------------------------------------------
   // Drop counter
   // ------------------------------------------------------------------
   logic [15:0] drop_q, drop_d;

   // Saturating count of rejected snapshots; a clear wins over an increment.
   always_comb begin
      drop_d = drop_q;
      if (drop_clr_i) begin
         drop_d = '0;
      end else if (drop && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end
   end

   // Drop counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   // ------------------------------------------------------------------
   // Output FSM
   // ------------------------------------------------------------------
   // State and beat index registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   // Next state: IDLE waits for a buffered snapshot; STREAM walks the beat
   // index on each handshake and returns to IDLE after the last beat.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_d = ST_STREAM;
               beat_d  = '0;
            end
         end
         ST_STREAM: begin
            if (handshake) begin
               if (beat_q == LastIdx) begin
                  state_d = ST_IDLE;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            beat_d  = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output datapath
   // ------------------------------------------------------------------
   logic [EntryW-1:0]   head;
   logic [CntWidth-1:0] head_lanes [NumCounters];

   // Split the head entry into per-counter lanes and select the current beat;
   // data is forced to zero outside STREAM so idle outputs read as 0.
   always_comb begin
      head = mem_q[rd_ptr_q];
      for (int k = 0; k < int'(NumCounters); k++) begin
         head_lanes[k] = head[k*CntWidth +: CntWidth];
      end
      sample_valid_o = (state_q == ST_STREAM);
      sample_data_o  = sample_valid_o ? head_lanes[beat_q] : '0;
      sample_idx_o   = beat_q;
      sample_last_o  = sample_valid_o && (beat_q == LastIdx);
      busy_o         = !fifo_empty || sample_valid_o;
      drop_cnt_o     = drop_q;
      state_dbg_o    = state_q;
   end

endmodule

// File: doc/perf_counter_sampler.md
Name: perf_counter_sampler

Overview:
- Sits directly downstream of the hardware performance counter block and consumes its six 64-bit generic counter values (mhpmcounter3..8).
- Takes a snapshot of all counters on a programmable cycle interval or on a software trigger.
- Buffers snapshots in a small FIFO and streams them out one 64-bit beat at a time over a valid/ready interface to the trace/debug sink.
- Counts snapshots dropped because the FIFO was full.

Parameters:
NumCounters, 6, number of counter inputs sampled per snapshot (1..8)
FifoDepth, 4, snapshot FIFO entries (power of two, >=2)
CntWidth, 64, width of each counter value

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
en_i  in  1  sampling enable; interval timer runs only when high
debug_mode_i  in  1  core in debug mode; freezes the interval timer and blocks triggers
interval_i  in  32  sampling period in cycles; 0 = periodic sampling off
snap_req_i  in  1  single-cycle software snapshot request
counter_i  in  NumCounters*CntWidth  counter values, counter k at bits [k*CntWidth +: CntWidth]
sample_valid_o  out  1  output beat valid
sample_ready_i  in  1  sink accepts beat
sample_data_o  out  CntWidth  counter value of the current beat
sample_idx_o  out  3  counter index of the current beat (0 = mhpmcounter3)
sample_last_o  out  1  last beat of the snapshot
drop_cnt_o  out  16  snapshots dropped on FIFO full; saturating
drop_clr_i  in  1  clears drop_cnt_o
busy_o  out  1  FIFO non-empty or stream in progress

Behaviour:
- Reset: timer=0, FIFO empty, state IDLE, beat index=0, drop_cnt_o=0. All outputs are 0 during and after reset.
- Interval timer:
  - Increments each cycle while en_i && !debug_mode_i && interval_i!=0.
  - When timer==interval_i-1, it wraps to 0 and generates a periodic trigger that same cycle.
  - en_i low holds the timer at 0.
  - A change of interval_i mid-count takes effect at the next compare. If the timer is already above the new interval_i-1, the timer wraps at 2^32 without a trigger.
- Trigger:
  - trig = (periodic trigger || snap_req_i) && !debug_mode_i. Simultaneous periodic and software triggers produce one snapshot.
  - On trig, counter_i is written into the FIFO at the next clock edge (one entry = all NumCounters values).
  - If the FIFO is full, nothing is written and drop_cnt_o increments, saturating at 16'hFFFF.
  - drop_clr_i has priority over an increment in the same cycle.
- A push and a pop in the same cycle while the FIFO is full is allowed (pop first). No drop occurs.
- Output FSM:
  - IDLE: sample_valid_o=0. If the FIFO is non-empty, go to STREAM with beat index=0. The earliest first beat is 2 cycles after trig (one cycle to write, one to enter STREAM).
  - STREAM: sample_valid_o=1; sample_data_o = head entry value at the beat index; sample_idx_o = beat index; sample_last_o = (beat index == NumCounters-1).
  - On a valid&&ready handshake, increment the beat index.
  - On a handshake of the last beat: pop the head, reset the beat index to 0, go to IDLE.
- Stream rules:
  - Data and index hold stable while valid && !ready.
  - Valid never drops before a handshake.
- busy_o = FIFO non-empty || state==STREAM.
- Reset mid-stream: the FIFO is discarded and the FSM returns to IDLE the next cycle. sample_valid_o=0 with no partial beats.

Optional Feature:
- Macro PERF_SAMPLER_DELTA_EN.
- Defined:
  - A prev register (NumCounters*CntWidth, reset 0) is updated with counter_i on every accepted push.
  - The value written to the FIFO is counter_i - prev, modulo 2^CntWidth, so a counter wrap yields the correct small delta.
  - A dropped snapshot does not update prev, so the next delta covers the gap.
  - The first snapshot after reset equals the absolute value.
- Not defined: absolute values are stored and there is no prev register.

Test Plan:
- interval_i=10, en_i=1, counter_i[0] constant 5, sink always ready -> first snapshot pushed 10 cycles after en_i rises. Six beats follow with idx 0..5 and sample_last_o only on idx 5. Repeats every 10 cycles.
- snap_req_i pulse together with a periodic trigger -> exactly one snapshot and 6 beats.
- sample_ready_i=0, 6 triggers with FifoDepth=4 -> FIFO holds 4 entries, drop_cnt_o=2. Assert drop_clr_i -> 0. Release ready -> 24 beats in order with data stable while stalled.
- debug_mode_i=1 for 20 cycles with interval_i=8 -> timer frozen, no snapshots, snap_req_i ignored. Timer resumes from its held value after debug_mode_i falls.
- rst_i asserted during beat 3 -> next cycle sample_valid_o=0, busy_o=0, drop_cnt_o=0.
- PERF_SAMPLER_DELTA_EN: counter 0 = 64'hFFFF_FFFF_FFFF_FFF0, then 64'h10 at the next snapshot -> beats 0xFFFF_FFFF_FFFF_FFF0, then 0x20.
